// File: rtl/cmd_deframer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_deframer_pkg : opcodes, FSM states and frame decode helper       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cmd_deframer_pkg;

    localparam logic [1:0] OP_SET_OFFSET = 2'd0;
    localparam logic [1:0] OP_RELOAD     = 2'd1;
    localparam logic [1:0] OP_QUERY      = 2'd2;
    localparam logic [1:0] OP_DAC        = 2'd3;

    localparam int HDR_FLAG_BIT   = 7;
    localparam int OFFSET_FIELD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_D1   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]                op;
        logic [6:0]                index;
        logic [OFFSET_FIELD_W-1:0] offset;
        logic                      dac_sel;
        logic [7:0]                dac_value;
    } cmd_t;

    // Only the 7 payload bits of each byte carry information.
    function automatic cmd_t decode_frame(input logic [6:0] hdr,
                                          input logic [6:0] b1,
                                          input logic [6:0] b2);
        cmd_t c;
        c.op        = hdr[6:5];
        c.index     = {hdr[4:0], b1[6:5]};
        c.offset    = {b1[4:0], b2};
        c.dac_sel   = hdr[4];
        c.dac_value = {b1[0], b2};
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_deframer_frame_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_timer : inter-byte idle counter with one-cycle expire pulse    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             at_last;

    assign at_last  = (cnt_q == CNT_LAST);
    // A clear in the same cycle (accepted byte) suppresses the expiry.
    assign expire_o = enable_i && !clear_i && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !at_last) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_deframer : 3-byte UART frame to control-core command deframer    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cmd_deframer #(
    parameter int OUTPUTS        = 88,
    parameter int OFFSET_WIDTH   = 11,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [6:0]            cmd_index,
    output logic [OFFSET_WIDTH:0] cmd_offset,
    output logic                  cmd_dac_sel,
    output logic [7:0]            cmd_dac_value,
    output logic [7:0]            err_count,
    output logic                  frame_timeout
);
    import cmd_deframer_pkg::*;

    localparam logic [7:0] INDEX_LIMIT = 8'(OUTPUTS);

    state_e                state_q;
    logic [6:0]            hdr_q;
    logic [6:0]            b1_q;
    logic                  in_ready_q;
    logic                  cmd_valid_q;
    logic [1:0]            cmd_op_q;
    logic [6:0]            cmd_index_q;
    logic [OFFSET_WIDTH:0] cmd_offset_q;
    logic                  cmd_dac_sel_q;
    logic [7:0]            cmd_dac_value_q;
    logic [7:0]            err_count_q;
    logic [7:0]            err_count_d;
    logic                  frame_timeout_q;

    logic                  byte_acc;
    logic                  is_hdr;
    logic                  timer_run;
    logic                  timer_clear;
    logic                  timer_expire;
    logic                  frame_ok;
    logic                  err_inc;
    cmd_t                  frame_dec;

    assign byte_acc    = in_valid && in_ready_q;
    assign is_hdr      = in_data[HDR_FLAG_BIT];
    assign timer_run   = (state_q == ST_HDR) || (state_q == ST_D1);
    assign timer_clear = !timer_run || byte_acc;

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (timer_clear),
        .enable_i(timer_run),
        .expire_o(timer_expire)
    );

    // Decode assumes in_data is the final data byte; only used in D1.
    assign frame_dec = decode_frame(hdr_q, b1_q, in_data[6:0]);
    assign frame_ok  = (frame_dec.op != OP_SET_OFFSET) ||
                       ({1'b0, frame_dec.index} < INDEX_LIMIT);

    always_comb begin
        err_inc = 1'b0;
        case (state_q)
            ST_IDLE: err_inc = byte_acc && !is_hdr;
            ST_HDR:  err_inc = (byte_acc && is_hdr) || timer_expire;
            ST_D1:   err_inc = (byte_acc && (is_hdr || !frame_ok)) || timer_expire;
            default: err_inc = 1'b0;
        endcase
    end

    // Coincident error sources collapse into a single saturating increment.
    assign err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1
                                                             : err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            hdr_q           <= '0;
            b1_q            <= '0;
            in_ready_q      <= 1'b0;
            cmd_valid_q     <= 1'b0;
            cmd_op_q        <= '0;
            cmd_index_q     <= '0;
            cmd_offset_q    <= '0;
            cmd_dac_sel_q   <= 1'b0;
            cmd_dac_value_q <= '0;
            err_count_q     <= '0;
            frame_timeout_q <= 1'b0;
        end else begin
            in_ready_q      <= 1'b1;
            frame_timeout_q <= 1'b0;
            err_count_q     <= err_count_d;
            case (state_q)
                ST_IDLE: begin
                    if (byte_acc && is_hdr) begin
                        hdr_q   <= in_data[6:0];
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (byte_acc) begin
                        if (is_hdr) begin
                            hdr_q <= in_data[6:0];
                        end else begin
                            b1_q    <= in_data[6:0];
                            state_q <= ST_D1;
                        end
                    end else if (timer_expire) begin
                        state_q         <= ST_IDLE;
                        frame_timeout_q <= 1'b1;
                    end
                end
                ST_D1: begin
                    if (byte_acc) begin
                        if (is_hdr) begin
                            hdr_q   <= in_data[6:0];
                            state_q <= ST_HDR;
                        end else if (frame_ok) begin
                            cmd_op_q        <= frame_dec.op;
                            cmd_index_q     <= frame_dec.index;
                            cmd_offset_q    <= (OFFSET_WIDTH+1)'(frame_dec.offset);
                            cmd_dac_sel_q   <= frame_dec.dac_sel;
                            cmd_dac_value_q <= frame_dec.dac_value;
                            cmd_valid_q     <= 1'b1;
                            in_ready_q      <= 1'b0;
                            state_q         <= ST_OUT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (timer_expire) begin
                        state_q         <= ST_IDLE;
                        frame_timeout_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_op        = cmd_op_q;
    assign cmd_index     = cmd_index_q;
    assign cmd_offset    = cmd_offset_q;
    assign cmd_dac_sel   = cmd_dac_sel_q;
    assign cmd_dac_value = cmd_dac_value_q;
    assign err_count     = err_count_q;
    assign frame_timeout = frame_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmd_deframer : scoreboard bench for cmd_deframer                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cmd_deframer;

    localparam int OUTPUTS      = 88;
    localparam int OFFSET_WIDTH = 11;
    localparam int TMO          = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [6:0]            cmd_index;
    logic [OFFSET_WIDTH:0] cmd_offset;
    logic                  cmd_dac_sel;
    logic [7:0]            cmd_dac_value;
    logic [7:0]            err_count;
    logic                  frame_timeout;

    cmd_deframer #(
        .OUTPUTS       (OUTPUTS),
        .OFFSET_WIDTH  (OFFSET_WIDTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_index    (cmd_index),
        .cmd_offset   (cmd_offset),
        .cmd_dac_sel  (cmd_dac_sel),
        .cmd_dac_value(cmd_dac_value),
        .err_count    (err_count),
        .frame_timeout(frame_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int index;
        int offset;
        int dac_sel;
        int dac_value;
    } cmd_s;

    cmd_s exp_q[$];
    int   part[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   last_stamp = 0;
    int   m_err      = 0;
    int   tmo_exp    = 0;
    int   tmo_seen   = 0;
    int   ready_mode = 0;

    always @(negedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    // Reference model: frame assembly from the byte-level rules.
    task automatic model_byte(input logic [7:0] b, input int stamp);
        int   v;
        cmd_s c;
        v = int'(b);
        if (part.size() != 0 && (stamp - last_stamp) > TMO) begin
            bump_err();
            tmo_exp++;
            part.delete();
        end
        last_stamp = stamp;
        if (v >= 128) begin
            if (part.size() != 0) bump_err();
            part.delete();
            part.push_back(v);
        end else if (part.size() == 0) begin
            bump_err();
        end else begin
            part.push_back(v);
            if (part.size() == 3) begin
                c.op        = (part[0] / 32) % 4;
                c.index     = (part[0] % 32) * 4 + (part[1] / 32) % 4;
                c.offset    = (part[1] % 32) * 128 + (part[2] % 128);
                c.dac_sel   = (part[0] / 16) % 2;
                c.dac_value = (part[1] % 2) * 128 + (part[2] % 128);
                if (c.op == 0 && c.index >= OUTPUTS) bump_err();
                else exp_q.push_back(c);
                part.delete();
            end
        end
    endtask

    task automatic model_reset();
        part.delete();
        exp_q.delete();
        m_err = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_wait: byte 0x%02h in_ready=0 expected 1", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_byte(b, cyc);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic rand_gap();
        int g;
        g = $urandom_range(0, 19);
        if (g < 12)       idle(0);
        else if (g < 17)  idle($urandom_range(1, 3));
        else if (g == 17) idle(TMO - 1);
        else              idle(TMO);
    endtask

    task automatic settle_check(input string tag);
        repeat (TMO + 3) @(posedge clk);
        #1;
        if (part.size() != 0 && (cyc - last_stamp) >= TMO) begin
            bump_err();
            tmo_exp++;
            part.delete();
        end
        chk({tag, "_err_count"}, 64'(err_count), 64'(m_err));
        chk({tag, "_timeouts"}, 64'(tmo_seen), 64'(tmo_exp));
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_outputs", 64'({in_ready, cmd_valid, cmd_op, cmd_index, cmd_offset,
                                      cmd_dac_sel, cmd_dac_value, err_count, frame_timeout}), 64'd0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("in_ready_first_cycle", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    endtask

    initial begin
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       cmd_ready = 1'b1;
                1:       cmd_ready = 1'b0;
                default: cmd_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks hold-stability.
    initial begin
        cmd_s        e;
        logic [29:0] held_v;
        logic [29:0] cur_v;
        bit          held;
        held = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clk);
            cur_v = {cmd_op, cmd_index, cmd_offset, cmd_dac_sel, cmd_dac_value};
            if (rst) begin
                held = 1'b0;
            end else begin
                if (frame_timeout) tmo_seen++;
                if (held) begin
                    chk("valid_held", 64'(cmd_valid), 64'd1);
                    chk("cmd_stable", 64'(cur_v), 64'(held_v));
                end
                if (cmd_valid) begin
                    chk("in_ready_in_out", 64'(in_ready), 64'd0);
                    if (cmd_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_cmd: got op=%0d index=%0d expected none",
                                     cmd_op, cmd_index);
                        end else begin
                            e = exp_q.pop_front();
                            chk("cmd_op", 64'(cmd_op), 64'(e.op));
                            chk("cmd_index", 64'(cmd_index), 64'(e.index));
                            chk("cmd_offset", 64'(cmd_offset), 64'(e.offset));
                            chk("cmd_dac_sel", 64'(cmd_dac_sel), 64'(e.dac_sel));
                            chk("cmd_dac_value", 64'(cmd_dac_value), 64'(e.dac_value));
                        end
                        held = 1'b0;
                    end else begin
                        held   = 1'b1;
                        held_v = cur_v;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();

        send3(8'h85, 8'h4A, 8'h33);
        settle_check("set_offset");

        send3(8'hE0, 8'h01, 8'h7F);
        send3(8'hF0, 8'h01, 8'h00);
        settle_check("dac");

        send3(8'h99, 8'h00, 8'h00);
        send3(8'hA0, 8'h00, 8'h00);
        settle_check("range");

        send_byte(8'h12);
        send_byte(8'h85);
        send3(8'h80, 8'h00, 8'h00);
        settle_check("resync");

        send_byte(8'h85);
        settle_check("timeout");
        send_byte(8'h4A);
        send_byte(8'h33);
        settle_check("after_timeout");

        send_byte(8'h85);
        idle(TMO - 1);
        send_byte(8'h4A);
        idle(TMO - 1);
        send_byte(8'h33);
        settle_check("expiry_byte_wins");

        send_byte(8'h85);
        idle(TMO);
        send_byte(8'h4A);
        send_byte(8'h33);
        settle_check("expiry_plus_one");

        ready_mode = 1;
        send3(8'hC3, 8'h2B, 8'h6C);
        idle(10);
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_cmd_valid", 64'(cmd_valid), 64'd1);
        ready_mode = 0;
        settle_check("backpressure");

        send_byte(8'h85);
        send_byte(8'h4A);
        do_reset();
        send3(8'h85, 8'h4A, 8'h33);
        settle_check("reset_mid_frame");

        ready_mode = 1;
        send3(8'hA5, 8'h11, 8'h22);
        idle(2);
        do_reset();
        ready_mode = 0;
        send3(8'hE0, 8'h01, 8'h7F);
        settle_check("reset_mid_out");

        ready_mode = 2;
        for (int k = 0; k < 150; k++) begin
            int         r;
            logic [7:0] h;
            logic [7:0] b1;
            logic [7:0] b2;
            r  = $urandom_range(0, 9);
            h  = 8'h80 | 8'($urandom_range(0, 127));
            b1 = 8'($urandom_range(0, 127));
            b2 = 8'($urandom_range(0, 127));
            if (r == 0) begin
                send_byte(b1);
            end else if (r == 1) begin
                send_byte(h);
                rand_gap();
            end else begin
                send_byte(h);
                rand_gap();
                send_byte(b1);
                rand_gap();
                send_byte(b2);
            end
        end
        ready_mode = 0;
        settle_check("random");

        for (int k = 0; k < 300; k++) send_byte(8'($urandom_range(0, 127)));
        settle_check("saturate");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
